// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the clk_sys reset sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        HOLD       = 2'd0,
        PERIPH_REL = 2'd1,
        RUN        = 2'd2,
        SW_ASSERT  = 2'd3
    } rst_seq_state_e;

    // Encoding of last_cause_o.
    localparam logic CAUSE_EXT = 1'b0;
    localparam logic CAUSE_SW  = 1'b1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rst_sync_xil.sv
// Reset deassertion synchronizer: async assert, release after SYNC_STAGES clk_sys edges.
// Latency: sync_rst falls after the SYNC_STAGES-th rising edge following rst_sys release.
// Backpressure: none; free-running on clk_sys.
//
// Ports:
//   clk_sys   destination clock
//   rst_sys   asynchronous active-high reset (asserts sync_rst immediately)
//   sync_rst  active-high reset, deassertion synchronous to clk_sys
module rst_sync_xil #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_sys,
    input  logic rst_sys,
    output logic sync_rst
);

    // Every stage is a potential metastability catcher, so keep them packed
    // together and away from retiming.
    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b0};
        end
    end

    assign sync_rst = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/rst_seq_xil.sv
// Ordered reset release (peripheral, then core) plus software-requested reset sequencing.
// Latency: periph after SYNC_STAGES+HOLD_CYCLES edges, core CORE_DELAY edges later.
// Backpressure: none; sw_rst_req_i is a level that holds the resets for as long as it is high.
//
// Ports:
//   clk_sys        system clock
//   rst_sys        asynchronous active-high reset (PLL lock AND board reset, inverted)
//   sw_rst_req_i   synchronous, level-sensitive software/debug reset request
//   periph_rst_no  peripheral reset, active-low, registered
//   core_rst_no    core reset, active-low, registered
//   seq_done_o     both resets released
//   sw_rst_cnt_o   saturating count of accepted software resets since rst_sys
//   last_cause_o   cause of the most recent reset (CAUSE_EXT / CAUSE_SW)
module rst_seq_xil
    import rst_seq_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int CORE_DELAY  = 8,
    parameter int CNT_W       = 8
) (
    input  logic             clk_sys,
    input  logic             rst_sys,
    input  logic             sw_rst_req_i,
    output logic             periph_rst_no,
    output logic             core_rst_no,
    output logic             seq_done_o,
    output logic [CNT_W-1:0] sw_rst_cnt_o,
    output logic             last_cause_o
);

    localparam int CW = $clog2(max_int(HOLD_CYCLES, CORE_DELAY)) + 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] CORE_LAST = CW'(CORE_DELAY - 1);

    logic sync_rst;

    rst_seq_state_e   state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             periph_q, periph_d;
    logic             core_q, core_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] sw_cnt_q, sw_cnt_d;
    logic             cause_q, cause_d;

    rst_sync_xil #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_sys  (clk_sys),
        .rst_sys  (rst_sys),
        .sync_rst (sync_rst)
    );

    always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys) begin
            state_q  <= HOLD;
            cnt_q    <= '0;
            periph_q <= 1'b0;
            core_q   <= 1'b0;
            done_q   <= 1'b0;
            sw_cnt_q <= '0;
            cause_q  <= CAUSE_EXT;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            periph_q <= periph_d;
            core_q   <= core_d;
            done_q   <= done_d;
            sw_cnt_q <= sw_cnt_d;
            cause_q  <= cause_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        periph_d = periph_q;
        core_d   = core_q;
        done_d   = done_q;
        sw_cnt_d = sw_cnt_q;
        cause_d  = cause_q;

        if (sync_rst) begin
            // Synchronizer still flushing: nothing may start counting yet.
            state_d  = HOLD;
            cnt_d    = '0;
            periph_d = 1'b0;
            core_d   = 1'b0;
            done_d   = 1'b0;
        end else begin
            unique case (state_q)
                HOLD: begin
                    core_d = 1'b0;
                    done_d = 1'b0;
                    if (sw_rst_req_i) begin
                        // A request before the sequence completes just restarts
                        // the hold window; it is not a counted software reset.
                        cnt_d    = '0;
                        periph_d = 1'b0;
                    end else if (cnt_q == HOLD_LAST) begin
                        state_d  = PERIPH_REL;
                        periph_d = 1'b1;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                PERIPH_REL: begin
                    if (sw_rst_req_i) begin
                        state_d  = HOLD;
                        cnt_d    = '0;
                        periph_d = 1'b0;
                        core_d   = 1'b0;
                        done_d   = 1'b0;
                    end else if (cnt_q == CORE_LAST) begin
                        state_d = RUN;
                        core_d  = 1'b1;
                        done_d  = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                RUN: begin
                    if (sw_rst_req_i) begin
                        state_d  = SW_ASSERT;
                        periph_d = 1'b0;
                        core_d   = 1'b0;
                        done_d   = 1'b0;
                        cause_d  = CAUSE_SW;
                        if (sw_cnt_q != '1) begin
                            sw_cnt_d = sw_cnt_q + CNT_W'(1);
                        end
                    end
                end
                SW_ASSERT: begin
                    if (!sw_rst_req_i) begin
                        state_d = HOLD;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d  = HOLD;
                    cnt_d    = '0;
                    periph_d = 1'b0;
                    core_d   = 1'b0;
                    done_d   = 1'b0;
                end
            endcase
        end
    end

    assign periph_rst_no = periph_q;
    assign core_rst_no   = core_q;
    assign seq_done_o    = done_q;
    assign sw_rst_cnt_o  = sw_cnt_q;
    assign last_cause_o  = cause_q;

endmodule

// File: tb/tb_rst_seq_xil.sv
// Bench for rst_seq_xil: directed release timing plus randomized rst/request traffic.
// Latency: n/a.
// Backpressure: n/a.
module tb_rst_seq_xil;

    localparam int SYNC  = 2;
    localparam int HOLD  = 16;
    localparam int CORE  = 8;
    localparam int CNT_W = 2;
    localparam int VW    = 4 + CNT_W;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk_sys = 1'b0;
    logic             rst_sys;
    logic             sw_rst_req_i;
    logic             periph_rst_no;
    logic             core_rst_no;
    logic             seq_done_o;
    logic [CNT_W-1:0] sw_rst_cnt_o;
    logic             last_cause_o;

    rst_seq_xil #(
        .SYNC_STAGES (SYNC),
        .HOLD_CYCLES (HOLD),
        .CORE_DELAY  (CORE),
        .CNT_W       (CNT_W)
    ) dut (
        .clk_sys       (clk_sys),
        .rst_sys       (rst_sys),
        .sw_rst_req_i  (sw_rst_req_i),
        .periph_rst_no (periph_rst_no),
        .core_rst_no   (core_rst_no),
        .seq_done_o    (seq_done_o),
        .sw_rst_cnt_o  (sw_rst_cnt_o),
        .last_cause_o  (last_cause_o)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        int            edge_n;
        logic [VW-1:0] vec;
    } ev_t;

    ev_t exp_q[$];
    int  tests = 0;
    int  fails = 0;
    int  edge_no = 0;
    bit  started = 1'b0;

    // Reference model: a single "clean edge streak" since the last restart.
    // Peripheral is out once the streak reaches HOLD, core once it reaches
    // HOLD+CORE; a reset release starts the streak SYNC edges in the negative.
    int            m_streak;
    bit            m_sw;
    int            m_cnt;
    bit            m_cause;
    logic [VW-1:0] last_pushed;

    function automatic logic [VW-1:0] model_vec();
        logic p, c;
        logic [CNT_W-1:0] cb;
        p  = !m_sw && (m_streak >= HOLD);
        c  = !m_sw && (m_streak >= HOLD + CORE);
        cb = m_cnt[CNT_W-1:0];
        return {p, c, c, m_cause, cb};
    endfunction

    task automatic model_reset();
        m_streak = -SYNC;
        m_sw     = 1'b0;
        m_cnt    = 0;
        m_cause  = 1'b0;
    endtask

    task automatic model_step(input bit r, input bit q);
        if (r) begin
            model_reset();
        end else if (m_streak < 0) begin
            m_streak++;
        end else if (m_sw) begin
            if (!q) begin
                m_sw     = 1'b0;
                m_streak = 0;
            end
        end else if (q) begin
            if (m_streak >= HOLD + CORE) begin
                m_sw    = 1'b1;
                m_cause = 1'b1;
                if (m_cnt < CMAX) m_cnt++;
            end
            m_streak = 0;
        end else if (m_streak < HOLD + CORE) begin
            m_streak++;
        end
    endtask

    task automatic push_if_changed();
        logic [VW-1:0] v;
        v = model_vec();
        if (v !== last_pushed) begin
            exp_q.push_back('{edge_no, v});
            last_pushed = v;
        end
    endtask

    // One clock edge: advance the model with the inputs seen at the edge,
    // then drive the inputs for the following edge.
    task automatic tick(input bit nr, input bit nq);
        @(posedge clk_sys);
        edge_no++;
        model_step(rst_sys, sw_rst_req_i);
        #2;
        rst_sys      = nr;
        sw_rst_req_i = nq;
        if (nr) model_reset();
        push_if_changed();
    endtask

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // i = 1 is the first edge after this call starts; periph must be out from
    // edge pa on, core from edge ca on.
    task automatic run_check(input int n, input int pa, input int ca, input string tag);
        for (int i = 1; i <= n; i++) begin
            tick(1'b0, 1'b0);
            @(negedge clk_sys);
            chk($sformatf("%s_periph_e%0d", tag, i), int'(periph_rst_no), (i >= pa) ? 1 : 0);
            chk($sformatf("%s_core_e%0d", tag, i), int'(core_rst_no), (i >= ca) ? 1 : 0);
        end
    endtask

    // Monitor: every change of the DUT output vector must match the next
    // scoreboard entry, on the same edge.
    logic [VW-1:0] obs;
    logic [VW-1:0] prev_obs;
    ev_t           e;

    always @(negedge clk_sys) begin
        if (started) begin
            obs = {periph_rst_no, core_rst_no, seq_done_o, last_cause_o, sw_rst_cnt_o};
            tests++;
            if (core_rst_no && !periph_rst_no) begin
                fails++;
                $display("FAIL invariant at edge %0d: core_rst_no=1 with periph_rst_no=0", edge_no);
            end
            if (obs !== prev_obs) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL scoreboard unexpected change at edge %0d: got %b, none expected", edge_no, obs);
                end else begin
                    e = exp_q.pop_front();
                    if (e.edge_n != edge_no || e.vec !== obs) begin
                        fails++;
                        $display("FAIL scoreboard at edge %0d: got %b, expected %b at edge %0d",
                                 edge_no, obs, e.vec, e.edge_n);
                    end
                end
                prev_obs = obs;
            end else if (exp_q.size() != 0 && exp_q[0].edge_n <= edge_no) begin
                tests++;
                fails++;
                $display("FAIL scoreboard missing change at edge %0d: got %b, expected %b",
                         edge_no, obs, exp_q[0].vec);
                e = exp_q.pop_front();
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int rate;
        bit r, q;

        rst_sys      = 1'b1;
        sw_rst_req_i = 1'b0;
        model_reset();
        last_pushed = model_vec();
        prev_obs    = last_pushed;
        started     = 1'b1;

        // Reset state
        @(negedge clk_sys);
        chk("reset_periph", int'(periph_rst_no), 0);
        chk("reset_core", int'(core_rst_no), 0);
        chk("reset_done", int'(seq_done_o), 0);
        chk("reset_cnt", int'(sw_rst_cnt_o), 0);
        chk("reset_cause", int'(last_cause_o), 0);

        // Power-on: ~5 cycles of reset, released mid-period
        repeat (4) tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        run_check(30, SYNC + HOLD, SYNC + HOLD + CORE, "por");
        chk("por_done", int'(seq_done_o), 1);
        chk("por_cnt", int'(sw_rst_cnt_o), 0);
        chk("por_cause", int'(last_cause_o), 0);

        // Software reset: request sampled on 3 edges
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        @(negedge clk_sys);
        chk("sw_periph_low", int'(periph_rst_no), 0);
        chk("sw_core_low", int'(core_rst_no), 0);
        chk("sw_done_low", int'(seq_done_o), 0);
        chk("sw_cnt", int'(sw_rst_cnt_o), 1);
        chk("sw_cause", int'(last_cause_o), 1);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        run_check(30, HOLD + 1, HOLD + CORE + 1, "swrel");

        // Mid-sequence rst_sys
        tick(1'b1, 1'b0);
        @(negedge clk_sys);
        chk("mid_cnt_cleared", int'(sw_rst_cnt_o), 0);
        chk("mid_cause_cleared", int'(last_cause_o), 0);
        tick(1'b0, 1'b0);
        run_check(19, SYNC + HOLD, SYNC + HOLD + CORE, "mid_a");
        tick(1'b1, 1'b0);
        @(negedge clk_sys);
        chk("mid_async_periph", int'(periph_rst_no), 0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        run_check(30, SYNC + HOLD, SYNC + HOLD + CORE, "mid_b");

        // Request during HOLD, sampled at edge 10
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        run_check(8, SYNC + HOLD, SYNC + HOLD + CORE, "hreq_pre");
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        run_check(30, HOLD, HOLD + CORE, "hreq");
        chk("hreq_cnt", int'(sw_rst_cnt_o), 0);
        chk("hreq_cause", int'(last_cause_o), 0);

        // Saturation of the 2-bit counter
        for (int k = 1; k <= 5; k++) begin
            tick(1'b0, 1'b1);
            tick(1'b0, 1'b0);
            repeat (30) tick(1'b0, 1'b0);
            @(negedge clk_sys);
            chk($sformatf("sat_cnt_%0d", k), int'(sw_rst_cnt_o), (k < CMAX) ? k : CMAX);
            chk($sformatf("sat_cause_%0d", k), int'(last_cause_o), 1);
        end

        // Random traffic, checked by the scoreboard and the invariant
        rate = 0;
        for (int c = 0; c < 10000; c++) begin
            if (c % 64 == 0) begin
                case ($urandom_range(0, 3))
                    0, 1:    rate = 0;
                    2:       rate = 3;
                    default: rate = 20;
                endcase
            end
            r = ($urandom_range(0, 199) == 0);
            q = ($urandom_range(0, 99) < rate);
            tick(r, q);
        end
        repeat (40) tick(1'b0, 1'b0);
        @(negedge clk_sys);
        chk("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
